// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC control path: opcode values, controller
// state encoding and the select codes driven onto the datapath muxes.
package sisc_pkg;

  // Opcode values; HLT is all-ones of the opcode width and is decoded in place.
  localparam int unsigned OP_NOOP = 0;
  localparam int unsigned OP_LOD  = 1;
  localparam int unsigned OP_STR  = 2;
  localparam int unsigned OP_SWP  = 3;
  localparam int unsigned OP_BRA  = 4;
  localparam int unsigned OP_BRR  = 5;
  localparam int unsigned OP_BNE  = 6;
  localparam int unsigned OP_BNR  = 7;
  localparam int unsigned OP_ALU  = 8;

  // Controller state encoding (fixed; exposed on the debug state port).
  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6,
    ST_ERR     = 3'd7
  } state_e;

  // ALU operand select.
  localparam logic [1:0] ALU_REG  = 2'b00;
  localparam logic [1:0] ALU_IMM  = 2'b01;
  localparam logic [1:0] ALU_NONE = 2'b10;

  // Register-file write-back source.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_SWP = 2'b10;

  // Memory address source.
  localparam logic [1:0] MM_IMM = 2'b00;
  localparam logic [1:0] MM_REG = 2'b01;

  // True for the four conditional-branch opcodes.
  function automatic logic is_branch_op(input int unsigned op);
    return (op == OP_BRA) || (op == OP_BRR) || (op == OP_BNE) || (op == OP_BNR);
  endfunction

endpackage

// File: rtl/ctrl_wait_ctr.sv
// Memory-wait counter for the control unit.
//   clk, rst_f : clock, asynchronous active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : count one wait cycle
//   tc_c       : combinational flag, high when the count is one short of MAX,
//                i.e. the current wait cycle is the MAX-th
module ctrl_wait_ctr
  #(
    parameter int unsigned MAX = 15
  )
  (
    input  logic clk,
    input  logic rst_f,
    input  logic clr,
    input  logic en,
    output logic tc_c
  );

  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  // Wait-cycle count register.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  // Terminal count: this wait cycle would bring the count to MAX.
  assign tc_c = (cnt == W'(MAX - 1));

endmodule

// File: rtl/ctrl_mc.sv
// Multi-cycle control unit for the SISC processor.
//   clk, rst_f  : clock, asynchronous active-low reset
//   opcode      : current instruction opcode
//   mm          : addressing mode / branch mask, mm[CCW-1] is the immediate bit
//   stat        : ALU status flags
//   mem_ack     : one-cycle data-memory completion strobe
//   run         : resume pulse, honoured only in HALT
//   pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, rb_sel, dm_we,
//   mem_req, halted, mem_err : datapath controls and status
//   alu_op, wb_sel, mm_sel   : datapath mux selects
//   state       : present state, for debug
// Outputs are decoded combinationally from the present state and the
// instruction fields, so a reset is visible on them without a clock edge.
module ctrl_mc
  import sisc_pkg::*;
  #(
    parameter int unsigned OPW    = 4,
    parameter int unsigned CCW    = 4,
    parameter int unsigned MEM_TO = 15
  )
  (
    input  logic           clk,
    input  logic           rst_f,
    input  logic [OPW-1:0] opcode,
    input  logic [CCW-1:0] mm,
    input  logic [CCW-1:0] stat,
    input  logic           mem_ack,
    input  logic           run,
    output logic           pc_rst,
    output logic           pc_write,
    output logic           pc_sel,
    output logic           br_sel,
    output logic           ir_load,
    output logic           rf_we,
    output logic           rb_sel,
    output logic           dm_we,
    output logic           mem_req,
    output logic           halted,
    output logic           mem_err,
    output logic [1:0]     alu_op,
    output logic [1:0]     wb_sel,
    output logic [1:0]     mm_sel,
    output logic [2:0]     state
  );

  state_e      state_q;
  state_e      state_d;
  int unsigned op;
  logic        is_hlt;
  logic        is_lod;
  logic        is_str;
  logic        is_swp;
  logic        is_alu;
  logic        is_mem;
  logic        is_branch;
  logic        is_abs_br;
  logic        imm;
  logic        cc_hit;
  logic        br_taken;
  logic [1:0]  alu_sel;
  logic        wait_clr;
  logic        wait_en;
  logic        wait_tc;

  // Instruction field decode.
  assign op        = 32'(opcode);
  assign is_hlt    = &opcode;
  assign is_lod    = (op == OP_LOD);
  assign is_str    = (op == OP_STR);
  assign is_swp    = (op == OP_SWP);
  assign is_alu    = (op == OP_ALU);
  assign is_mem    = is_lod | is_str | is_swp;
  assign is_branch = is_branch_op(op);
  assign is_abs_br = (op == OP_BRA) || (op == OP_BNE);
  assign imm       = mm[CCW-1];
  assign cc_hit    = |(mm & stat);

  // BRA/BRR branch when any masked flag is set, BNE/BNR when none is.
  assign br_taken  = (((op == OP_BRA) || (op == OP_BRR)) &&  cc_hit) ||
                     (((op == OP_BNE) || (op == OP_BNR)) && !cc_hit);

  // ALU operand select shared by EXECUTE and MEM.
  always_comb begin
    alu_sel = ALU_NONE;
    if (is_alu || is_lod || is_str) begin
      alu_sel = imm ? ALU_IMM : ALU_REG;
    end
  end

  // The counter is held clear outside MEM so every MEM visit starts at zero.
  assign wait_clr = (state_q != ST_MEM);
  assign wait_en  = (state_q == ST_MEM) && !mem_ack;

  ctrl_wait_ctr #(
    .MAX (MEM_TO)
  ) u_wait_ctr (
    .clk   (clk),
    .rst_f (rst_f),
    .clr   (wait_clr),
    .en    (wait_en),
    .tc_c  (wait_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    ir_load  = 1'b0;
    rf_we    = 1'b0;
    rb_sel   = 1'b0;
    dm_we    = 1'b0;
    mem_req  = 1'b0;
    halted   = 1'b0;
    mem_err  = 1'b0;
    alu_op   = ALU_NONE;
    wb_sel   = WB_ALU;
    mm_sel   = MM_IMM;

    case (state_q)
      ST_START: begin
        pc_rst  = 1'b1;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        state_d  = ST_DECODE;
      end

      ST_DECODE: begin
        if (is_hlt) begin
          state_d = ST_HALT;
        end else if (is_branch) begin
          br_sel = is_abs_br;
          if (br_taken) begin
            pc_write = 1'b1;
            pc_sel   = 1'b1;
          end
          state_d = ST_FETCH;
        end else if (is_mem || is_alu) begin
          state_d = ST_EXECUTE;
        end else begin
          // NOOP and unassigned opcodes fall straight back to fetch.
          state_d = ST_FETCH;
        end
      end

      ST_EXECUTE: begin
        alu_op = alu_sel;
        if (is_mem) begin
          state_d = ST_MEM;
        end else if (is_alu) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_MEM: begin
        mem_req = 1'b1;
        rb_sel  = 1'b1;
        dm_we   = is_str;
        mm_sel  = imm ? MM_IMM : MM_REG;
        alu_op  = alu_sel;
        // An acknowledge on the terminal wait cycle still completes the access.
        if (mem_ack) begin
          state_d = ST_WB;
        end else if (wait_tc) begin
          state_d = ST_ERR;
        end
      end

      ST_WB: begin
        if (is_alu) begin
          rf_we  = 1'b1;
          wb_sel = WB_ALU;
        end else if (is_lod) begin
          rf_we  = 1'b1;
          wb_sel = WB_MEM;
        end else if (is_swp) begin
          rf_we  = 1'b1;
          wb_sel = WB_SWP;
        end
        state_d = ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
        if (run) begin
          state_d = ST_FETCH;
        end
      end

      ST_ERR: begin
        // Sticky until reset; run has no effect here.
        halted  = 1'b1;
        mem_err = 1'b1;
      end

      default: begin
        state_d = ST_START;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_ctrl_mc.sv
// Scoreboard bench for ctrl_mc: the stimulus process queues the expected
// output vector for each checked cycle; the monitor pops and compares on the
// falling clock edge, or immediately on mon_ev for asynchronous events.
module tb_ctrl_mc;

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_EXE   = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  // Flag bits: {pc_rst,pc_write,pc_sel,br_sel,ir_load,rf_we,rb_sel,dm_we,mem_req,halted,mem_err}
  localparam logic [10:0] F_NONE  = 11'h000;
  localparam logic [10:0] F_PCRST = 11'h400;
  localparam logic [10:0] F_PCW   = 11'h200;
  localparam logic [10:0] F_PCSEL = 11'h100;
  localparam logic [10:0] F_BRSEL = 11'h080;
  localparam logic [10:0] F_IRL   = 11'h040;
  localparam logic [10:0] F_RFWE  = 11'h020;
  localparam logic [10:0] F_RBSEL = 11'h010;
  localparam logic [10:0] F_DMWE  = 11'h008;
  localparam logic [10:0] F_MREQ  = 11'h004;
  localparam logic [10:0] F_HALT  = 11'h002;
  localparam logic [10:0] F_MERR  = 11'h001;

  localparam logic [1:0] A_REG = 2'b00, A_IMM = 2'b01, A_NONE = 2'b10;
  localparam logic [1:0] W_ALU = 2'b00, W_MEM = 2'b01, W_SWP = 2'b10;
  localparam logic [1:0] M_IMM = 2'b00, M_REG = 2'b01;

  typedef struct {
    string       name;
    logic [19:0] vec;
  } exp_t;

  logic       clk;
  logic       rst_f;
  logic [3:0] opcode;
  logic [3:0] mm;
  logic [3:0] stat;
  logic       mem_ack;
  logic       run;
  logic       pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we;
  logic       rb_sel, dm_we, mem_req, halted, mem_err;
  logic [1:0] alu_op, wb_sel, mm_sel;
  logic [2:0] state;
  logic [19:0] obs;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  event mon_ev;

  ctrl_mc #(
    .OPW    (4),
    .CCW    (4),
    .MEM_TO (4)
  ) dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .opcode   (opcode),
    .mm       (mm),
    .stat     (stat),
    .mem_ack  (mem_ack),
    .run      (run),
    .pc_rst   (pc_rst),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .br_sel   (br_sel),
    .ir_load  (ir_load),
    .rf_we    (rf_we),
    .rb_sel   (rb_sel),
    .dm_we    (dm_we),
    .mem_req  (mem_req),
    .halted   (halted),
    .mem_err  (mem_err),
    .alu_op   (alu_op),
    .wb_sel   (wb_sel),
    .mm_sel   (mm_sel),
    .state    (state)
  );

  assign obs = {state, pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we,
                rb_sel, dm_we, mem_req, halted, mem_err, alu_op, wb_sel, mm_sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] ev(input logic [2:0] st, input logic [10:0] f,
                                     input logic [1:0] a, input logic [1:0] w,
                                     input logic [1:0] m);
    return {st, f, a, w, m};
  endfunction

  task automatic expect_out(input string nm, input logic [19:0] v);
    exp_t e;
    e.name = nm;
    e.vec  = v;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation for the current cycle, then advance one cycle.
  task automatic chk(input string nm, input logic [19:0] v);
    expect_out(nm, v);
    step();
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or mon_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (obs !== e.vec) begin
          errors++;
          $display("FAIL %s got=%05h exp=%05h", e.name, obs, e.vec);
        end
      end
    end
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst_f = 1'b0; opcode = 4'd0; mm = 4'd0; stat = 4'd0; mem_ack = 1'b0; run = 1'b0;
    step();
    expect_out("reset_start", ev(S_START, F_PCRST, A_NONE, W_ALU, M_IMM));
    rst_f = 1'b1;
    step();

    // ALU register form
    opcode = 4'd8; mm = 4'd0;
    chk("alu_fetch",  ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));
    chk("alu_decode", ev(S_DEC,   F_NONE,        A_NONE, W_ALU, M_IMM));
    chk("alu_exec",   ev(S_EXE,   F_NONE,        A_REG,  W_ALU, M_IMM));
    chk("alu_wb",     ev(S_WB,    F_RFWE,        A_NONE, W_ALU, M_IMM));

    // ALU immediate form
    mm = 4'd8;
    chk("alui_fetch", ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));
    chk("alui_dec",   ev(S_DEC,   F_NONE,        A_NONE, W_ALU, M_IMM));
    chk("alui_exec",  ev(S_EXE,   F_NONE,        A_IMM,  W_ALU, M_IMM));
    chk("alui_wb",    ev(S_WB,    F_RFWE,        A_NONE, W_ALU, M_IMM));

    // LOD immediate, ack on the third MEM cycle
    opcode = 4'd1; mm = 4'd8;
    chk("lod_fetch", ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));
    chk("lod_dec",   ev(S_DEC,   F_NONE,        A_NONE, W_ALU, M_IMM));
    chk("lod_exec",  ev(S_EXE,   F_NONE,        A_IMM,  W_ALU, M_IMM));
    chk("lod_mem1",  ev(S_MEM,   F_RBSEL | F_MREQ, A_IMM, W_ALU, M_IMM));
    chk("lod_mem2",  ev(S_MEM,   F_RBSEL | F_MREQ, A_IMM, W_ALU, M_IMM));
    mem_ack = 1'b1;
    chk("lod_mem3",  ev(S_MEM,   F_RBSEL | F_MREQ, A_IMM, W_ALU, M_IMM));
    mem_ack = 1'b0;
    chk("lod_wb",    ev(S_WB,    F_RFWE,        A_NONE, W_MEM, M_IMM));

    // BNE taken then not taken
    opcode = 4'd6; mm = 4'b0001; stat = 4'b0000;
    chk("bne_fetch",  ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));
    chk("bne_taken",  ev(S_DEC,   F_PCW | F_PCSEL | F_BRSEL, A_NONE, W_ALU, M_IMM));
    chk("bne_back",   ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));
    stat = 4'b0001;
    chk("bne_ntaken", ev(S_DEC,   F_BRSEL,       A_NONE, W_ALU, M_IMM));

    // BRR taken then not taken
    opcode = 4'd5; mm = 4'b0011; stat = 4'b0010;
    chk("brr_fetch",  ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));
    chk("brr_taken",  ev(S_DEC,   F_PCW | F_PCSEL, A_NONE, W_ALU, M_IMM));
    stat = 4'b0100;
    chk("brr_fetch2", ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));
    chk("brr_ntaken", ev(S_DEC,   F_NONE,        A_NONE, W_ALU, M_IMM));

    // Unassigned opcode behaves as NOOP
    opcode = 4'd9; mm = 4'd0; stat = 4'd0;
    chk("unk_fetch", ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));
    chk("unk_dec",   ev(S_DEC,   F_NONE,        A_NONE, W_ALU, M_IMM));

    // SWP with register addressing, immediate ack
    opcode = 4'd3; mm = 4'd0;
    chk("swp_fetch", ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));
    chk("swp_dec",   ev(S_DEC,   F_NONE,        A_NONE, W_ALU, M_IMM));
    chk("swp_exec",  ev(S_EXE,   F_NONE,        A_NONE, W_ALU, M_IMM));
    mem_ack = 1'b1;
    chk("swp_mem",   ev(S_MEM,   F_RBSEL | F_MREQ, A_NONE, W_ALU, M_REG));
    mem_ack = 1'b0;
    chk("swp_wb",    ev(S_WB,    F_RFWE,        A_NONE, W_SWP, M_IMM));

    // STR without ack: timeout after four MEM cycles, sticky ERR
    opcode = 4'd2; mm = 4'd0;
    chk("str_fetch", ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));
    chk("str_dec",   ev(S_DEC,   F_NONE,        A_NONE, W_ALU, M_IMM));
    chk("str_exec",  ev(S_EXE,   F_NONE,        A_REG,  W_ALU, M_IMM));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("str_to_mem%0d", i + 1),
          ev(S_MEM, F_RBSEL | F_DMWE | F_MREQ, A_REG, W_ALU, M_REG));
    end
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("str_err%0d", i), ev(S_ERR, F_HALT | F_MERR, A_NONE, W_ALU, M_IMM));
    end
    run = 1'b0;
    rst_f = 1'b0;
    chk("err_rst",      ev(S_START, F_PCRST, A_NONE, W_ALU, M_IMM));
    rst_f = 1'b1;
    chk("err_rst_rel",  ev(S_START, F_PCRST, A_NONE, W_ALU, M_IMM));

    // STR with ack on the terminal wait cycle goes to WB
    chk("stra_fetch", ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));
    chk("stra_dec",   ev(S_DEC,   F_NONE,        A_NONE, W_ALU, M_IMM));
    chk("stra_exec",  ev(S_EXE,   F_NONE,        A_REG,  W_ALU, M_IMM));
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ack = 1'b1;
      chk($sformatf("stra_mem%0d", i + 1),
          ev(S_MEM, F_RBSEL | F_DMWE | F_MREQ, A_REG, W_ALU, M_REG));
    end
    mem_ack = 1'b0;
    chk("stra_wb",    ev(S_WB,    F_NONE,        A_NONE, W_ALU, M_IMM));

    // HLT: stays halted (stray ack ignored), run resumes fetch
    opcode = 4'd15;
    chk("hlt_fetch", ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));
    chk("hlt_dec",   ev(S_DEC,   F_NONE,        A_NONE, W_ALU, M_IMM));
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hlt_hold%0d", i), ev(S_HALT, F_HALT, A_NONE, W_ALU, M_IMM));
    end
    mem_ack = 1'b0;
    run = 1'b1;
    chk("hlt_run",    ev(S_HALT,  F_HALT,        A_NONE, W_ALU, M_IMM));
    run = 1'b0;
    chk("hlt_resume", ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));

    // Asynchronous reset while MEM is requesting
    opcode = 4'd1; mm = 4'd0;
    chk("ar_dec",  ev(S_DEC, F_NONE, A_NONE, W_ALU, M_IMM));
    chk("ar_exec", ev(S_EXE, F_NONE, A_REG,  W_ALU, M_IMM));
    expect_out("ar_mem", ev(S_MEM, F_RBSEL | F_MREQ, A_REG, W_ALU, M_REG));
    @(negedge clk);
    #1;
    rst_f = 1'b0;
    #1;
    expect_out("ar_async", ev(S_START, F_PCRST, A_NONE, W_ALU, M_IMM));
    -> mon_ev;
    #1;
    step();
    rst_f = 1'b1;
    chk("ar_release", ev(S_START, F_PCRST,       A_NONE, W_ALU, M_IMM));
    chk("ar_fetch",   ev(S_FETCH, F_PCW | F_IRL, A_NONE, W_ALU, M_IMM));

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_mc.md
CTRL_MC -- requirements
Module: ctrl_mc

Interface
REQ-001 Parameter OPW, default 4: opcode width.
REQ-002 Parameter CCW, default 4: condition-code (stat/mm mask) width.
REQ-003 Parameter MEM_TO, default 15: maximum wait cycles for mem_ack before error; range 1..255.
REQ-004 clk  in  1  system clock; all state updates occur on its rising edge.
REQ-005 rst_f  in  1  asynchronous, active-low reset.
REQ-006 opcode  in  OPW  current instruction opcode (NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU=8, HLT=all-ones).
REQ-007 mm  in  CCW  addressing mode / branch mask; immediate bit = mm[CCW-1].
REQ-008 stat  in  CCW  status flags from ALU.
REQ-009 mem_ack  in  1  data-memory completion strobe, one cycle.
REQ-010 run  in  1  resume pulse, honoured only in HALT.
REQ-011 Outputs (1 bit): pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, rb_sel, dm_we, mem_req, halted, mem_err.
REQ-012 Outputs (2 bits): alu_op, wb_sel, mm_sel; state (3 bits) exposes present state for debug.

Function
REQ-013 States: START=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6, ERR=7; encoding is fixed.
REQ-014 START -> FETCH unconditionally; FETCH -> DECODE unconditionally.
REQ-015 DECODE: opcode HLT -> HALT; branch opcode -> FETCH; NOOP -> FETCH; all others -> EXECUTE.
REQ-016 Branch taken: BRA/BRR when (mm & stat) != 0; BNE/BNR when (mm & stat) == 0; pc_write=1, pc_sel=1 in DECODE only when taken.
REQ-017 br_sel=1 for BRA/BNE (absolute), 0 for BRR/BNR (relative) in DECODE; 0 in every other state.
REQ-018 EXECUTE: LOD/STR/SWP -> MEM; ALU -> WB.
REQ-019 alu_op in EXECUTE and MEM: ALU register=00, ALU immediate=01, LOD/STR with immediate bit set=01, LOD/STR with immediate bit clear=00; 10 otherwise.
REQ-020 MEM: mem_req=1 every cycle in state; dm_we=1 for STR only; rb_sel=1; mm_sel=00 if immediate bit set, else 01.
REQ-021 MEM exits to WB on the cycle mem_ack=1; mem_ack sampled outside MEM is ignored.
REQ-022 Wait counter clears on MEM entry, increments each MEM cycle without mem_ack; reaching MEM_TO without mem_ack -> ERR.
REQ-023 mem_ack arriving on the same cycle the counter reaches MEM_TO wins: transition to WB, not ERR.
REQ-024 WB: rf_we=1 for ALU (wb_sel=00), LOD (wb_sel=01), SWP (wb_sel=10); STR: rf_we=0. WB -> FETCH.
REQ-025 FETCH: ir_load=1, pc_write=1, pc_sel=0.
REQ-026 HALT: halted=1, all write enables 0; run=1 -> FETCH, else stay.
REQ-027 ERR: mem_err=1, halted=1; sticky until rst_f asserted; run ignored.
REQ-028 All outputs not explicitly driven in a state are 0 (alu_op 10); outputs are combinational from state, opcode, mm, stat only.
REQ-029 Unknown opcodes (9..HLT-1) behave as NOOP.

Reset
REQ-030 rst_f low forces state=START and wait counter=0 immediately, independent of clk, including mid-MEM.
REQ-031 While in START: pc_rst=1, all other outputs 0, alu_op=10, state=000.
REQ-032 First rising clk after rst_f deasserts moves START -> FETCH.

Structure
REQ-033 Opcode values, state encodings, and alu_op/wb_sel/mm_sel codes reside in shared package sisc_pkg.
REQ-034 Wait counter is a sub-module ctrl_wait_ctr (clear, enable, terminal-count flag, width $clog2(MEM_TO+1)).
REQ-035 No simulation-only halt ($stop) in RTL; halting is signalled via halted.

Verification
REQ-036 ALU reg (opcode 8, mm 0): FETCH,DECODE,EXECUTE,WB over 4 cycles; rf_we=1, wb_sel=00 in WB only.
REQ-037 LOD imm (opcode 1, mm 8), mem_ack on 3rd MEM cycle: mem_req high 3 cycles; WB rf_we=1, wb_sel=01.
REQ-038 BNE (opcode 6, mm 0001, stat 0000): pc_write=1, br_sel=1 in DECODE; next state FETCH; with stat 0001 pc_write=0.
REQ-039 STR with MEM_TO=4, no mem_ack: ERR after 4 MEM cycles, mem_err=1 held; mem_ack on 4th cycle -> WB.
REQ-040 HLT: state HALT, halted=1 for 10 cycles; run pulse -> FETCH next cycle, halted=0.
REQ-041 rst_f low mid-MEM with mem_req=1: mem_req drops and pc_rst=1 without waiting for clk.
